// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S bus-master transmitter with one-deep stereo sample buffer
//
// Divides MCLK into BCLK and WCLK and shifts stereo WIDTH-bit samples out MSB first,
// one BCLK after each WCLK transition. Frames with no buffered pair go out as zeros
// and raise a one-cycle UNDERRUN_OUT pulse.
//
// Ports:
//   MCLK_IN           master clock, all logic on its rising edge
//   RST_IN            asynchronous active-high reset
//   SAMPLE_L_IN       left sample (two's complement)
//   SAMPLE_R_IN       right sample (two's complement)
//   SAMPLE_VALID_IN   source offers a stereo pair
//   SAMPLE_READY_OUT  buffer empty, pair accepted when VALID is also high
//   I2S_BCLK_OUT      bit clock
//   I2S_WCLK_OUT      word clock, 0 = left, 1 = right
//   I2S_DOUT_OUT      serial data, changes on BCLK falling edges
//   UNDERRUN_OUT      one-cycle pulse when a frame is loaded with no sample

module i2s_master_tx #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic             MCLK_IN,
  input  logic             RST_IN,
  input  logic [WIDTH-1:0] SAMPLE_L_IN,
  input  logic [WIDTH-1:0] SAMPLE_R_IN,
  input  logic             SAMPLE_VALID_IN,
  output logic             SAMPLE_READY_OUT,
  output logic             I2S_BCLK_OUT,
  output logic             I2S_WCLK_OUT,
  output logic             I2S_DOUT_OUT,
  output logic             UNDERRUN_OUT
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             wclk_q, wclk_d;
  logic             dout_q, dout_d;
  logic             underrun_q, underrun_d;
  logic             ready_q, ready_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] buf_l_q, buf_l_d;
  logic [WIDTH-1:0] buf_r_q, buf_r_d;
  logic [WIDTH-1:0] frame_l_q, frame_l_d;
  logic [WIDTH-1:0] frame_r_q, frame_r_d;

  logic             fall;
  logic             load;
  logic             xfer;
  logic [BIT_W-1:0] next_pos;
  logic             right_slot;
  logic [BIT_W-1:0] slot_pos;
  logic [WIDTH-1:0] slot_word;
  logic [WIDTH-1:0] slot_shift;

  // Divider, bit counter and serial outputs.
  always_comb begin
    fall      = (div_cnt_q == DIV_LAST);
    div_cnt_d = fall ? '0 : div_cnt_q + 1'b1;
    // Registered from the next count so BCLK lines up with div_cnt itself.
    bclk_d    = (div_cnt_d >= DIV_HALF);

    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end

    // WCLK looks one position ahead so it leads the slot MSB by one BCLK.
    next_pos   = (bit_cnt_d == BIT_LAST) ? '0 : bit_cnt_d + 1'b1;
    right_slot = (bit_cnt_d >= SLOT_LEN);
    slot_pos   = right_slot ? bit_cnt_d - SLOT_LEN : bit_cnt_d;
    slot_word  = right_slot ? frame_r_q : frame_l_q;
    // Positions past WIDTH shift every sample bit out, leaving the pad zeros.
    slot_shift = slot_word << slot_pos;

    wclk_d = wclk_q;
    dout_d = dout_q;
    if (fall) begin
      wclk_d = (next_pos >= SLOT_LEN);
      dout_d = slot_shift[WIDTH-1];
    end
  end

  // Sample buffer, frame load and handshake.
  always_comb begin
    load = fall && (bit_cnt_d == BIT_LAST);
    xfer = SAMPLE_VALID_IN & ready_q;

    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    underrun_d = 1'b0;

    if (load) begin
      if (buf_full_q) begin
        frame_l_d  = buf_l_q;
        frame_r_d  = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        frame_l_d  = '0;
        frame_r_d  = '0;
        underrun_d = 1'b1;
      end
    end

    // Applied after the load: a pair arriving on an empty-buffer load edge
    // misses this frame but is kept for the next one.
    if (xfer) begin
      buf_l_d    = SAMPLE_L_IN;
      buf_r_d    = SAMPLE_R_IN;
      buf_full_d = 1'b1;
    end

    ready_d = ~buf_full_d;
  end

  always_ff @(posedge MCLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      wclk_q     <= 1'b0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      wclk_q     <= wclk_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
    end
  end

  assign SAMPLE_READY_OUT = ready_q;
  assign I2S_BCLK_OUT     = bclk_q;
  assign I2S_WCLK_OUT     = wclk_q;
  assign I2S_DOUT_OUT     = dout_q;
  assign UNDERRUN_OUT     = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb/tb_i2s_master_tx.sv - self-checking bench for i2s_master_tx
`timescale 1ns/1ps

module tb_i2s_master_tx;

  localparam int WIDTH = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SLOT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] l_in = '0;
  logic [WIDTH-1:0] r_in = '0;
  logic             valid = 1'b0;
  logic             ready, bclk, wclk, dout, urun;

  i2s_master_tx #(.WIDTH(WIDTH), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .MCLK_IN          (clk),
    .RST_IN           (rst),
    .SAMPLE_L_IN      (l_in),
    .SAMPLE_R_IN      (r_in),
    .SAMPLE_VALID_IN  (valid),
    .SAMPLE_READY_OUT (ready),
    .I2S_BCLK_OUT     (bclk),
    .I2S_WCLK_OUT     (wclk),
    .I2S_DOUT_OUT     (dout),
    .UNDERRUN_OUT     (urun)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [WIDTH-1:0] l; logic [WIDTH-1:0] r; } xfer_t;
  typedef struct { logic [WIDTH-1:0] l; logic [WIDTH-1:0] r; logic tail_ok; } frame_t;

  int     tests = 0;
  int     fails = 0;
  int     n;
  xfer_t  xq[$];
  int     uq[$];
  frame_t fq[$];

  logic             prev_bclk, prev_wclk, prev_dout;
  logic             collecting, cur_ch, have_left;
  logic [SLOT-1:0]  shreg, left_slot;
  logic             xfer_now;
  logic             chk_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MCLK edge (counted from reset release) on which frame k is loaded.
  function automatic int load_edge(input int k);
    return DIV * ((FRAME - 1) + FRAME * k);
  endfunction

  task automatic clear_model();
    n = 0;
    xq.delete();
    uq.delete();
    fq.delete();
    prev_bclk  = 1'b0;
    prev_wclk  = 1'b0;
    prev_dout  = 1'b0;
    collecting = 1'b0;
    cur_ch     = 1'b0;
    have_left  = 1'b0;
    shreg      = '0;
    left_slot  = '0;
    chk_ready  = 1'b0;
    xfer_now   = 1'b0;
  endtask

  // Receiver: a slot is the SLOT bits following a WCLK change, sampled on BCLK rise.
  task automatic decode_bit();
    frame_t f;
    if (wclk !== prev_wclk) begin
      if (collecting) begin
        shreg = {shreg[SLOT-2:0], dout};
        if (cur_ch == 1'b0) begin
          left_slot = shreg;
          have_left = 1'b1;
        end else if (have_left) begin
          f.l       = left_slot[SLOT-1 -: WIDTH];
          f.r       = shreg[SLOT-1 -: WIDTH];
          f.tail_ok = (left_slot[SLOT-WIDTH-1:0] == '0) && (shreg[SLOT-WIDTH-1:0] == '0);
          fq.push_back(f);
          have_left = 1'b0;
        end
      end
      collecting = 1'b1;
      cur_ch     = wclk;
      shreg      = '0;
    end else if (collecting) begin
      shreg = {shreg[SLOT-2:0], dout};
    end
    prev_wclk = wclk;
  endtask

  task automatic tick();
    logic             pv, pr;
    logic [WIDTH-1:0] pl, pr_data;
    xfer_t            x;
    pv = valid; pr = ready; pl = l_in; pr_data = r_in;
    @(posedge clk);
    n++;
    #1;
    xfer_now = pv & pr;
    if (xfer_now) begin
      x.t = n; x.l = pl; x.r = pr_data;
      xq.push_back(x);
    end
    if (urun) uq.push_back(n);
    check("bclk_shape", bclk, ((n % DIV) >= DIV / 2));
    check("wclk_shape", wclk, ((((n / DIV) + 1) % FRAME) >= SLOT));
    if (dout !== prev_dout) check("dout_on_bclk_fall", n % DIV, 0);
    prev_dout = dout;
    if (chk_ready && n >= load_edge(0) && ((n - load_edge(0)) % (DIV * FRAME)) == 0)
      check("ready_after_load", ready, 1);
    if (bclk && !prev_bclk) decode_bit();
    prev_bclk = bclk;
  endtask

  task automatic run_until(input int target);
    while (n < target) tick();
  endtask

  task automatic wait_xfer(input string tag, input int budget);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!xfer_now && c < budget);
    check(tag, xfer_now, 1);
  endtask

  // Expects rst already high or raises it; releases between clock edges.
  task automatic reset_dut();
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_bclk", bclk, 0);
    check("rst_wclk", wclk, 0);
    check("rst_dout", dout, 0);
    check("rst_underrun", urun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    tick();
    check("ready_after_reset", ready, 1);
  endtask

  // Expected frames come from the transfer log: frame k carries the pair accepted
  // in [load(k-1), load(k)), else zeros with an underrun on load(k).
  task automatic verify(input string tag, input int nf);
    int               cnt, prev, lk, exp_u;
    logic [WIDTH-1:0] el, er;
    logic             seen;
    check($sformatf("%s_frames_decoded", tag), fq.size() >= nf, 1);
    exp_u = 0;
    for (int k = 0; k < nf; k++) begin
      prev = (k == 0) ? 0 : load_edge(k - 1);
      lk   = load_edge(k);
      cnt  = 0; el = '0; er = '0;
      foreach (xq[i]) begin
        if (xq[i].t >= prev && xq[i].t < lk) begin
          cnt++; el = xq[i].l; er = xq[i].r;
        end
      end
      check($sformatf("%s_xfers_frame%0d", tag, k), cnt <= 1, 1);
      if (cnt == 0) exp_u++;
      seen = 1'b0;
      foreach (uq[i]) if (uq[i] == lk) seen = 1'b1;
      check($sformatf("%s_underrun_frame%0d", tag, k), seen, (cnt == 0));
      if (k < fq.size()) begin
        check($sformatf("%s_left_frame%0d", tag, k), fq[k].l, el);
        check($sformatf("%s_right_frame%0d", tag, k), fq[k].r, er);
        check($sformatf("%s_pad_frame%0d", tag, k), fq[k].tail_ok, 1);
      end
    end
    cnt = 0;
    foreach (uq[i]) if (uq[i] < load_edge(nf)) cnt++;
    check($sformatf("%s_underrun_count", tag), cnt, exp_u);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] base, v, sl, sr;
    int               cnt;

    // 1: idle, zero frames with one underrun each
    reset_dut();
    run_until(load_edge(2) + 8);
    verify("t1", 2);

    // 2: one fixed pair before the first load
    reset_dut();
    run_until(10);
    l_in = 24'hA5A5A5; r_in = 24'h5A5A5A; valid = 1'b1;
    wait_xfer("t2_accept", 40);
    valid = 1'b0;
    run_until(load_edge(2) + 8);
    verify("t2", 2);
    if (fq.size() > 0) begin
      check("t2_left_pattern", fq[0].l, 24'hA5A5A5);
      check("t2_right_pattern", fq[0].r, 24'h5A5A5A);
    end

    // 3: VALID held high, incrementing pairs
    reset_dut();
    base = WIDTH'($urandom);
    v = base; l_in = v; r_in = ~v; valid = 1'b1;
    chk_ready = 1'b1;
    while (n < load_edge(5) + 8) begin
      tick();
      if (xfer_now) begin
        v = v + 1'b1; l_in = v; r_in = ~v;
      end
    end
    chk_ready = 1'b0;
    valid = 1'b0;
    verify("t3", 5);
    check("t3_xfer_total", xq.size(), 7);
    for (int k = 0; k < 5; k++) begin
      if (k < fq.size()) begin
        sl = base + WIDTH'(k);
        check($sformatf("t3_seq_frame%0d", k), fq[k].l, sl);
      end
    end

    // 4: stream, withhold for three frames, resume
    reset_dut();
    l_in = WIDTH'($urandom); r_in = WIDTH'($urandom); valid = 1'b1;
    while (n < load_edge(0) + 4) begin
      tick();
      if (xfer_now) begin l_in = WIDTH'($urandom); r_in = WIDTH'($urandom); end
    end
    valid = 1'b0;
    run_until(load_edge(4) + 10);
    valid = 1'b1;
    while (n < load_edge(7) + 8) begin
      tick();
      if (xfer_now) begin l_in = WIDTH'($urandom); r_in = WIDTH'($urandom); end
    end
    valid = 1'b0;
    verify("t4", 7);
    cnt = 0;
    foreach (uq[i]) if (uq[i] > load_edge(1) && uq[i] <= load_edge(4)) cnt++;
    check("t4_gap_underruns", cnt, 3);

    // 5: transfer on the load edge with the buffer empty
    reset_dut();
    run_until(load_edge(0) - 1);
    sl = WIDTH'($urandom); sr = WIDTH'($urandom);
    l_in = sl; r_in = sr; valid = 1'b1;
    tick();
    check("t5_xfer_on_load", xfer_now, 1);
    check("t5_underrun_on_load", urun, 1);
    valid = 1'b0;
    run_until(load_edge(2) + 8);
    verify("t5", 2);
    if (fq.size() > 1) begin
      check("t5_deferred_left", fq[1].l, sl);
      check("t5_deferred_right", fq[1].r, sr);
    end

    // 6: sign extremes, then reset mid right slot with the buffer full
    reset_dut();
    l_in = 24'h800000; r_in = 24'h7FFFFF; valid = 1'b1;
    wait_xfer("t6_accept_a", 40);
    l_in = WIDTH'($urandom); r_in = WIDTH'($urandom);
    wait_xfer("t6_accept_b", DIV * FRAME + 8);
    l_in = WIDTH'($urandom); r_in = WIDTH'($urandom);
    wait_xfer("t6_accept_c", DIV * FRAME + 8);
    valid = 1'b0;
    run_until(load_edge(1) + DIV * (SLOT + 16));
    verify("t6", 1);
    if (fq.size() > 0) begin
      check("t6_left_min", fq[0].l, 24'h800000);
      check("t6_right_max", fq[0].r, 24'h7FFFFF);
    end
    rst = 1'b1;
    #1;
    check("t6_async_bclk", bclk, 0);
    check("t6_async_wclk", wclk, 0);
    check("t6_async_dout", dout, 0);
    check("t6_async_ready", ready, 0);
    check("t6_async_underrun", urun, 0);
    reset_dut();
    run_until(load_edge(1) + 8);
    verify("t6_after_reset", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S bus-master transmitter in the MCLK domain: divides MCLK into BCLK and WCLK and serialises stereo WIDTH-bit samples onto a data line, MSB first.
- Playback-direction counterpart of the capture path in main, which receives I2S_din0 against its own WCLK/BCLK.
- Samples arrive through a valid/ready port backed by a one-deep stereo buffer. Frames with no sample available are sent as zeros and flagged as underruns.

Parameters:
- WIDTH, 24: sample width in bits.
- SLOT_BITS, 32: BCLK periods per channel slot; must satisfy SLOT_BITS >= WIDTH+1.
- BCLK_DIV, 4: MCLK cycles per BCLK period; must be even and >= 2.

Ports:
- MCLK_IN  in  1  master clock; all logic is on its rising edge.
- RST_IN  in  1  asynchronous, active-high reset.
- SAMPLE_L_IN  in  WIDTH  left sample, two's complement.
- SAMPLE_R_IN  in  WIDTH  right sample, two's complement.
- SAMPLE_VALID_IN  in  1  source has a stereo pair on the sample inputs.
- SAMPLE_READY_OUT  out  1  buffer can accept a pair (buffer empty).
- I2S_BCLK_OUT  out  1  bit clock.
- I2S_WCLK_OUT  out  1  word clock; 0 = left, 1 = right.
- I2S_DOUT_OUT  out  1  serial data.
- UNDERRUN_OUT  out  1  one-cycle pulse when a frame is loaded with no sample available.

Behaviour:
- Reset values (while RST_IN is high, and on any reset mid-frame):
  - div_cnt=0, bit_cnt=0
  - I2S_BCLK_OUT=0, I2S_WCLK_OUT=0, I2S_DOUT_OUT=0, UNDERRUN_OUT=0
  - buffer empty, frame registers L/R = 0
  - SAMPLE_READY_OUT=0 during reset; it goes to 1 on the first cycle after reset is released.
  - A reset mid-frame discards any buffered and in-flight sample without raising UNDERRUN_OUT.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - I2S_BCLK_OUT is registered, equal to 1 exactly when div_cnt >= BCLK_DIV/2.
  - The wrap to 0 is the "fall event"; the BCLK falling edge occurs on that cycle.
- Bit counter:
  - bit_cnt counts 0..2*SLOT_BITS-1, advances on every fall event, and wraps.
  - Positions 0..SLOT_BITS-1 are the left slot; positions SLOT_BITS..2*SLOT_BITS-1 are the right slot.
- Word clock:
  - On each fall event, I2S_WCLK_OUT is registered as 1 iff ((new bit_cnt + 1) mod 2*SLOT_BITS) >= SLOT_BITS.
  - WCLK therefore changes one BCLK before each slot's MSB (standard I2S delay).
  - WCLK edges coincide with BCLK falling edges.
- Data:
  - On each fall event, with p = new bit_cnt mod SLOT_BITS and ch = left if new bit_cnt < SLOT_BITS, else right:
    - I2S_DOUT_OUT <= frame_ch[WIDTH-1-p] if p < WIDTH, otherwise 0.
  - Data changes only on BCLK falling edges; a receiver samples on BCLK rising edges.
- Handshake:
  - A transfer occurs when SAMPLE_VALID_IN & SAMPLE_READY_OUT are both high; the pair is written to the buffer and SAMPLE_READY_OUT drops the next cycle.
  - The source must hold data stable while VALID is high and READY is low.
- Frame load (on the fall event entering bit_cnt = 2*SLOT_BITS-1):
  - Buffer full: copy the buffer to the frame registers, mark the buffer empty, raise SAMPLE_READY_OUT the next cycle.
  - Buffer empty: frame registers become 0 and UNDERRUN_OUT pulses for exactly one MCLK cycle.
  - Because the load happens one bit before the left MSB, the new left MSB appears on the next fall event.
- Simultaneous transfer and load with the buffer empty:
  - The load sees the buffer empty: underrun, zero frame.
  - The transferred pair lands in the buffer and is used for the next frame.
- Latency: a pair accepted at least one cycle before a load event has its left MSB on I2S_DOUT_OUT BCLK_DIV MCLK cycles after that event.
- Frame rate: MCLK / (BCLK_DIV * 2 * SLOT_BITS). With defaults and 24.576 MHz MCLK this is 96 kHz.

Test Plan:
1. Defaults; release reset; observe only. -> BCLK period is 4 MCLK at 50% duty. WCLK period is 256 MCLK, high for 128. WCLK edges align with BCLK falling edges. First frame is all zeros with one UNDERRUN pulse at the first load.
2. Before the first load, accept L=24'hA5A5A5, R=24'h5A5A5A; a bench decoder samples on BCLK rising edges. -> Left slot reads A5A5A5 MSB-first, starting one BCLK after WCLK falls, then 8 zero bits. Right slot reads 5A5A5A. UNDERRUN stays low for that frame.
3. Hold VALID=1 continuously, incrementing the pair on every transfer (L=n, R=~n). -> Exactly one transfer per frame. Consecutive frames carry n, n+1, n+2 with no drop or repeat. READY rises one cycle after each load event.
4. Withhold VALID for 3 frames, then resume. -> Three zero frames with exactly one UNDERRUN pulse each. The next frame carries the resumed sample.
5. Assert VALID in the same cycle as a load event with the buffer empty. -> Underrun pulse and a zero frame now. That sample is transmitted in the following frame.
6. Send L=24'h800000, R=24'h7FFFFF; pulse RST_IN mid right slot. -> Sign bits are serialised exactly. All outputs go to zero immediately on reset, and the buffer is empty after release: the first frame is zero with an underrun pulse.
